// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle adder/subtractor that processes CHUNK bits
// per clock and carries between slices in a carry register. Operands are captured
// on the input handshake, and the result is held until the output handshake.
// Optional feature macro: ADDER_OVF_EN adds the signed-overflow output 'ovf'.

// One CHUNK-bit slice of the adder; the top reuses a single instance every cycle.
module csa_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   // CHUNK-bit add with carry-in and carry-out
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
   end

endmodule

module chunked_serial_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Reject geometries that would leave a partial slice
   generate
      if (CHUNK < 1 || NCHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
         $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q,   opa_d;
   logic [WIDTH-1:0] opb_q,   opb_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q,   idx_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
`ifdef ADDER_OVF_EN
   logic             ovf_q,   ovf_d;
`endif

   logic [31:0]      off;
   logic [CHUNK-1:0] sl_a, sl_b, sl_s;
   logic             sl_co;
   logic             accept;

   // Bit offset of the slice being worked on, and the operand slices at it.
   // Shifting instead of an indexed part-select keeps the index width exact.
   always_comb begin
      off  = 32'(idx_q) * 32'(CHUNK);
      sl_a = CHUNK'(opa_q >> off);
      sl_b = CHUNK'(opb_q >> off);
   end

   csa_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
   );

   assign in_ready  = (state_q == S_IDLE) & ~rst;
   assign out_valid = (state_q == S_DONE);
   assign accept    = in_valid & in_ready;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

   // Next-state logic: capture on accept, one slice per BUSY cycle, hold in DONE.
   // Subtraction is folded into the capture (a + ~b + ~cin), so after accept the
   // datapath is a plain adder and 'sub' does not need to be kept.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub ? ~cin : cin;
               idx_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            sum_d   = (sum_q & ~(SLICE_MASK << off)) | (WIDTH'(sl_s) << off);
            carry_d = sl_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = sl_co;
`ifdef ADDER_OVF_EN
               // Equal operand signs with a differing result sign is the same
               // condition as carry-into-MSB differing from carry-out-of-MSB.
               ovf_d   = (sl_a[CHUNK-1] ~^ sl_b[CHUNK-1]) & (sl_s[CHUNK-1] ^ sl_a[CHUNK-1]);
`endif
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule
